// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared encodings and state type for the memory-access stage
//
// Contents:
//   RS_ALU / RS_MEM / RS_PC4  write-back source encodings (2'b11 behaves as ALU)
//   memstate_t                access FSM states IDLE, REQ, WAIT
//   needs_mem()               true when an EX/MEM slot must touch data memory
package pipeline_pkg;

  localparam logic [1:0] RS_ALU = 2'b00;
  localparam logic [1:0] RS_MEM = 2'b01;
  localparam logic [1:0] RS_PC4 = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } memstate_t;

  function automatic logic needs_mem(input logic       valid,
                                     input logic       mem_write,
                                     input logic [1:0] result_src);
    return valid && (mem_write || (result_src == RS_MEM));
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - data-memory request/response bus
//
// Signals:
//   memReqValid/memReqReady  request handshake (stage -> memory)
//   memReqWrite              1 = store, 0 = load
//   memAddr/memWData         request address and store data
//   memRspValid/memRData     load response (memory -> stage), no back-pressure
// Modports: master = memory-access stage, slave = data memory.
interface mem_access_stage_if;

  logic        memReqValid;
  logic        memReqReady;
  logic        memReqWrite;
  logic [31:0] memAddr;
  logic [31:0] memWData;
  logic        memRspValid;
  logic [31:0] memRData;

  modport master (
    output memReqValid, memReqWrite, memAddr, memWData,
    input  memReqReady, memRspValid, memRData
  );

  modport slave (
    input  memReqValid, memReqWrite, memAddr, memWData,
    output memReqReady, memRspValid, memRData
  );

endinterface

// File: rtl/mem_timeout_counter.sv
// rtl/mem_timeout_counter.sv - cycle counter flagging a load response that never arrives
//
// Ports:
//   clk, reset  clock and asynchronous active-low reset
//   clear       synchronous clear, wins over enable
//   enable      count this cycle
//   expired     high during the LIMIT-th enabled cycle since the last clear
module mem_timeout_counter #(
  parameter int LIMIT = 255,
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // The count is the number of enabled cycles already elapsed, so the
  // LIMIT-th cycle sees LIMIT-1 and the owner can complete on that edge.
  assign expired = enable && (count_q == WIDTH'(LIMIT - 1));

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM pipeline stage: issues loads/stores, stalls EX/MEM, registers MEM/WB
//
// Optional feature macro: MEM_TIMEOUT_EN (WAIT-state watchdog and sticky errorOUT).
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   validIN .. ResultSrcIN      EX/MEM register outputs
//   stallOUT                    hold request to EX/MEM (its we = ~stallOUT)
//   mem                         data-memory bus (master side)
//   resultOUT, rdAddrOUT,
//   RegWriteOUT, validOUT       registered MEM/WB result, validOUT pulses once per retirement
//   errorOUT                    sticky timeout flag (0 unless MEM_TIMEOUT_EN)
module mem_access_stage
  import pipeline_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                validIN,
  input  logic [31:0]         aluResultIN,
  input  logic [31:0]         writeDataIN,
  input  logic [4:0]          rdAddrIN,
  input  logic [31:0]         pcPlus4IN,
  input  logic                RegWriteIN,
  input  logic                MemWriteIN,
  input  logic [1:0]          ResultSrcIN,
  output logic                stallOUT,
  mem_access_stage_if.master  mem,
  output logic [31:0]         resultOUT,
  output logic [4:0]          rdAddrOUT,
  output logic                RegWriteOUT,
  output logic                validOUT,
  output logic                errorOUT
);

  memstate_t   state_q, state_d;

  // Fields of the in-flight memory instruction.
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [4:0]  lat_rd_q, lat_rd_d;
  logic        lat_rw_q, lat_rw_d;
  logic        lat_mw_q, lat_mw_d;
  logic [1:0]  lat_rs_q, lat_rs_d;

  // MEM/WB register.
  logic [31:0] result_q, result_d;
  logic [4:0]  rd_out_q, rd_out_d;
  logic        regwrite_q, regwrite_d;
  logic        valid_q, valid_d;

  logic        stall_raw;
  logic        req_valid;
  logic        timeout_hit;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    lat_rd_d   = lat_rd_q;
    lat_rw_d   = lat_rw_q;
    lat_mw_d   = lat_mw_q;
    lat_rs_d   = lat_rs_q;
    result_d   = result_q;
    rd_out_d   = rd_out_q;
    regwrite_d = 1'b0;
    valid_d    = 1'b0;
    stall_raw  = 1'b0;
    req_valid  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (needs_mem(validIN, MemWriteIN, ResultSrcIN)) begin
          stall_raw = 1'b1;
          addr_d    = aluResultIN;
          wdata_d   = writeDataIN;
          lat_rd_d  = rdAddrIN;
          lat_rw_d  = RegWriteIN;
          lat_mw_d  = MemWriteIN;
          lat_rs_d  = ResultSrcIN;
          state_d   = REQ;
        end else if (validIN) begin
          result_d   = (ResultSrcIN == RS_PC4) ? pcPlus4IN : aluResultIN;
          rd_out_d   = rdAddrIN;
          regwrite_d = RegWriteIN;
          valid_d    = 1'b1;
        end
      end

      REQ: begin
        req_valid = 1'b1;
        if (mem.memReqReady && lat_mw_q) begin
          // Store retires on acceptance; stall drops so EX/MEM advances now.
          result_d   = addr_q;
          rd_out_d   = lat_rd_q;
          regwrite_d = lat_rw_q;
          valid_d    = 1'b1;
          state_d    = IDLE;
        end else begin
          stall_raw = 1'b1;
          if (mem.memReqReady) begin
            state_d = WAIT;
          end
        end
      end

      WAIT: begin
        if (mem.memRspValid) begin
          result_d   = (lat_rs_q == RS_MEM) ? mem.memRData : addr_q;
          rd_out_d   = lat_rd_q;
          regwrite_d = lat_rw_q;
          valid_d    = 1'b1;
          state_d    = IDLE;
        end else if (timeout_hit) begin
          // Abandoned load retires as a harmless no-write.
          result_d   = '0;
          rd_out_d   = lat_rd_q;
          regwrite_d = 1'b0;
          valid_d    = 1'b1;
          state_d    = IDLE;
        end else begin
          stall_raw = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      lat_rd_q   <= '0;
      lat_rw_q   <= 1'b0;
      lat_mw_q   <= 1'b0;
      lat_rs_q   <= RS_ALU;
      result_q   <= '0;
      rd_out_q   <= '0;
      regwrite_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      lat_rd_q   <= lat_rd_d;
      lat_rw_q   <= lat_rw_d;
      lat_mw_q   <= lat_mw_d;
      lat_rs_q   <= lat_rs_d;
      result_q   <= result_d;
      rd_out_q   <= rd_out_d;
      regwrite_q <= regwrite_d;
      valid_q    <= valid_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int TW_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TW     = (TW_RAW < 8) ? 8 : TW_RAW;

  logic error_q, error_d;

  // Clearing whenever the FSM is outside WAIT restarts the count on each entry.
  mem_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES),
    .WIDTH (TW)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_q != WAIT),
    .enable  (state_q == WAIT),
    .expired (timeout_hit)
  );

  always_comb begin
    error_d = error_q;
    if ((state_q == WAIT) && !mem.memRspValid && timeout_hit) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      error_q <= 1'b0;
    end else begin
      error_q <= error_d;
    end
  end

  assign errorOUT = error_q;
`else
  logic [31:0] unused_timeout_cycles;

  assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
  assign timeout_hit           = 1'b0;
  assign errorOUT              = 1'b0;
`endif

  // Reset forces the stall low even though IDLE may be decoding a memory op.
  assign stallOUT        = stall_raw & reset;
  assign mem.memReqValid = req_valid;
  assign mem.memReqWrite = lat_mw_q;
  assign mem.memAddr     = addr_q;
  assign mem.memWData    = wdata_q;

  assign resultOUT   = result_q;
  assign rdAddrOUT   = rd_out_q;
  assign RegWriteOUT = regwrite_q;
  assign validOUT    = valid_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed self-checking bench for mem_access_stage
module tb_mem_access_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        validIN;
  logic [31:0] aluResultIN;
  logic [31:0] writeDataIN;
  logic [4:0]  rdAddrIN;
  logic [31:0] pcPlus4IN;
  logic        RegWriteIN;
  logic        MemWriteIN;
  logic [1:0]  ResultSrcIN;
  logic        stallOUT;
  logic [31:0] resultOUT;
  logic [4:0]  rdAddrOUT;
  logic        RegWriteOUT;
  logic        validOUT;
  logic        errorOUT;

  mem_access_stage_if mem_if ();

  mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .validIN     (validIN),
    .aluResultIN (aluResultIN),
    .writeDataIN (writeDataIN),
    .rdAddrIN    (rdAddrIN),
    .pcPlus4IN   (pcPlus4IN),
    .RegWriteIN  (RegWriteIN),
    .MemWriteIN  (MemWriteIN),
    .ResultSrcIN (ResultSrcIN),
    .stallOUT    (stallOUT),
    .mem         (mem_if),
    .resultOUT   (resultOUT),
    .rdAddrOUT   (rdAddrOUT),
    .RegWriteOUT (RegWriteOUT),
    .validOUT    (validOUT),
    .errorOUT    (errorOUT)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        rw;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   cyc      = 0;
  int   n_cmp    = 0;
  int   n_err    = 0;
  int   err_from = -1;
  int   ns, nr;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Retirement checker: every validOUT must match the oldest expected result
  // in the cycle the model predicts.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (validOUT) begin
        if (exp_q.size() == 0) begin
          chk("spurious_validOUT", 32'(validOUT), 32'd0);
        end else begin
          cur = exp_q.pop_front();
          chk("retire_cycle", 32'(cyc), 32'(cur.cyc));
          chk("resultOUT", resultOUT, cur.result);
          chk("rdAddrOUT", 32'(rdAddrOUT), 32'(cur.rd));
          chk("RegWriteOUT", 32'(RegWriteOUT), 32'(cur.rw));
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        chk("missing_validOUT", 32'(validOUT), 32'd1);
        cur = exp_q.pop_front();
      end
      chk("rw_without_valid", 32'(RegWriteOUT & ~validOUT), 32'd0);
      chk("errorOUT", 32'(errorOUT), 32'((err_from >= 0) && (cyc >= err_from)));
    end
  end

  // Applies one EX/MEM slot and plays the memory side: ready is held low for
  // rdly REQ cycles, the load response comes after wdly empty WAIT cycles, and
  // stray handshakes are driven wherever the stage must ignore them.
  task automatic issue(input logic v, input logic [31:0] alu, input logic [31:0] wd,
                       input logic [4:0] rd, input logic [31:0] pc4, input logic rw,
                       input logic mw, input logic [1:0] rs, input int rdly, input int wdly,
                       input logic [31:0] rdata, output int n_stall, output int n_req);
    logic acc, ld, tmo, req_exp;
    int   c, cyc0;
    exp_t e;
    @(posedge clk); #1;
    cyc0 = cyc;
    acc  = v && (mw || rs == 2'b01);
    ld   = acc && !mw;
    tmo  = 1'b0;
`ifdef MEM_TIMEOUT_EN
    tmo = ld && (wdly >= TO);
`endif
    if (!acc)     c = 0;
    else if (!ld) c = rdly + 1;
    else if (tmo) c = rdly + 1 + TO;
    else          c = rdly + 2 + wdly;
    if (v) begin
      if (!acc)     e.result = (rs == 2'b10) ? pc4 : alu;
      else if (!ld) e.result = alu;
      else if (tmo) e.result = 32'd0;
      else          e.result = rdata;
      e.rd  = rd;
      e.rw  = tmo ? 1'b0 : rw;
      e.cyc = cyc0 + c + 1;
      exp_q.push_back(e);
      if (tmo && err_from < 0) err_from = cyc0 + c + 1;
    end
    validIN = v; aluResultIN = alu; writeDataIN = wd; rdAddrIN = rd;
    pcPlus4IN = pc4; RegWriteIN = rw; MemWriteIN = mw; ResultSrcIN = rs;
    n_stall = 0;
    n_req   = 0;
    for (int k = 0; k <= c; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      req_exp = acc && (k >= 1) && (k <= rdly + 1);
      mem_if.memReqReady = (k == 0) || (acc && k >= rdly + 1);
      if (ld && !tmo && k == c) begin
        mem_if.memRspValid = 1'b1;
        mem_if.memRData    = rdata;
      end else if (k <= rdly + 1) begin
        mem_if.memRspValid = 1'b1;
        mem_if.memRData    = 32'hBAD0_0000 + 32'(k);
      end else begin
        mem_if.memRspValid = 1'b0;
        mem_if.memRData    = 32'hBAD1_0000;
      end
      @(negedge clk);
      chk("stallOUT", 32'(stallOUT), 32'(acc && (k < c)));
      chk("memReqValid", 32'(mem_if.memReqValid), 32'(req_exp));
      if (req_exp) begin
        chk("memAddr", mem_if.memAddr, alu);
        chk("memWData", mem_if.memWData, wd);
        chk("memReqWrite", 32'(mem_if.memReqWrite), 32'(mw));
      end
      n_stall += int'(stallOUT);
      n_req   += int'(mem_if.memReqValid);
    end
  endtask

  task automatic bubble_inputs();
    validIN = 1'b0; MemWriteIN = 1'b0; ResultSrcIN = 2'b00; RegWriteIN = 1'b0;
    mem_if.memReqReady = 1'b0; mem_if.memRspValid = 1'b0;
  endtask

  // Literal pin on the retirement cycle that follows an issue.
  task automatic pin(input string name, input logic [31:0] res, input logic [4:0] rd, input logic rw);
    @(posedge clk); #1;
    bubble_inputs();
    @(negedge clk);
    chk({name, "_valid"}, 32'(validOUT), 32'd1);
    chk({name, "_result"}, resultOUT, res);
    chk({name, "_rd"}, 32'(rdAddrOUT), 32'(rd));
    chk({name, "_rw"}, 32'(RegWriteOUT), 32'(rw));
  endtask

  task automatic reset_mid(input logic in_wait);
    @(posedge clk); #1;
    validIN = 1'b1; aluResultIN = 32'h200; rdAddrIN = 5'd9; RegWriteIN = 1'b1;
    MemWriteIN = 1'b0; ResultSrcIN = 2'b01;
    mem_if.memReqReady = 1'b0; mem_if.memRspValid = 1'b0;
    @(posedge clk); #1;
    if (in_wait) begin
      mem_if.memReqReady = 1'b1;
      @(posedge clk); #1;
      mem_if.memReqReady = 1'b0;
    end
    @(negedge clk);
    chk("pre_reset_stall", 32'(stallOUT), 32'd1);
    chk("pre_reset_req", 32'(mem_if.memReqValid), 32'(!in_wait));
    #2;
    reset    = 1'b0;
    err_from = -1;
    #1;
    chk("rst_memReqValid", 32'(mem_if.memReqValid), 32'd0);
    chk("rst_stallOUT", 32'(stallOUT), 32'd0);
    chk("rst_validOUT", 32'(validOUT), 32'd0);
    chk("rst_RegWriteOUT", 32'(RegWriteOUT), 32'd0);
    chk("rst_resultOUT", resultOUT, 32'd0);
    chk("rst_rdAddrOUT", 32'(rdAddrOUT), 32'd0);
    chk("rst_errorOUT", 32'(errorOUT), 32'd0);
    validIN = 1'b0;
    @(posedge clk); #1;
    mem_if.memRspValid = 1'b1; mem_if.memRData = 32'h5A5A_5A5A; mem_if.memReqReady = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    bubble_inputs();
    @(negedge clk);
    chk("post_reset_req", 32'(mem_if.memReqValid), 32'd0);
    chk("post_reset_stall", 32'(stallOUT), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    validIN = 1'b1; aluResultIN = 32'h80; writeDataIN = 32'h1; rdAddrIN = 5'd3;
    pcPlus4IN = 32'h4; RegWriteIN = 1'b1; MemWriteIN = 1'b1; ResultSrcIN = 2'b00;
    mem_if.memReqReady = 1'b0; mem_if.memRspValid = 1'b0; mem_if.memRData = 32'h0;
    repeat (2) @(negedge clk);
    chk("reset_stallOUT", 32'(stallOUT), 32'd0);
    chk("reset_memReqValid", 32'(mem_if.memReqValid), 32'd0);
    chk("reset_validOUT", 32'(validOUT), 32'd0);
    chk("reset_RegWriteOUT", 32'(RegWriteOUT), 32'd0);
    chk("reset_resultOUT", resultOUT, 32'd0);
    chk("reset_rdAddrOUT", 32'(rdAddrOUT), 32'd0);
    chk("reset_errorOUT", 32'(errorOUT), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    bubble_inputs();

    issue(1, 32'h1234, 32'h0, 5'd5, 32'h0, 1, 0, 2'b00, 0, 0, 32'h0, ns, nr);
    chk("alu_stall_cycles", 32'(ns), 32'd0);
    pin("alu", 32'h1234, 5'd5, 1'b1);

    issue(1, 32'h55, 32'h0, 5'd1, 32'h104, 1, 0, 2'b10, 0, 0, 32'h0, ns, nr);
    pin("jal", 32'h104, 5'd1, 1'b1);

    issue(1, 32'h11, 32'h0, 5'd2, 32'h9, 1, 0, 2'b00, 0, 0, 32'h0, ns, nr);
    issue(1, 32'h22, 32'h0, 5'd3, 32'h9, 1, 0, 2'b11, 0, 0, 32'h0, ns, nr);
    issue(1, 32'h33, 32'h0, 5'd4, 32'h9, 0, 0, 2'b10, 0, 0, 32'h0, ns, nr);
    issue(0, 32'h44, 32'h0, 5'd4, 32'h9, 1, 0, 2'b00, 0, 0, 32'h0, ns, nr);

    issue(1, 32'h80, 32'hDEADBEEF, 5'd0, 32'h0, 0, 1, 2'b00, 3, 0, 32'h0, ns, nr);
    chk("store_stall_cycles", 32'(ns), 32'd4);
    chk("store_req_cycles", 32'(nr), 32'd4);
    pin("store", 32'h80, 5'd0, 1'b0);

    issue(1, 32'h40, 32'h0, 5'd7, 32'h0, 1, 0, 2'b01, 0, 2, 32'hCAFEF00D, ns, nr);
    chk("load_stall_cycles", 32'(ns), 32'd4);
    pin("load", 32'hCAFEF00D, 5'd7, 1'b1);

    issue(1, 32'h44, 32'h0, 5'd8, 32'h0, 1, 0, 2'b01, 0, 0, 32'h0BADCAFE, ns, nr);
    chk("load_fast_stall", 32'(ns), 32'd2);
    issue(1, 32'h90, 32'h12345678, 5'd6, 32'h0, 1, 1, 2'b01, 0, 0, 32'h0, ns, nr);
    chk("store_fast_stall", 32'(ns), 32'd1);
    issue(1, 32'h48, 32'h0, 5'd10, 32'h0, 1, 0, 2'b01, 2, 1, 32'h600DF00D, ns, nr);
    issue(1, 32'h77, 32'h0, 5'd11, 32'h200, 1, 0, 2'b00, 0, 0, 32'h0, ns, nr);

    reset_mid(1'b0);
    reset_mid(1'b1);

    issue(1, 32'hABC, 32'h0, 5'd12, 32'h0, 1, 0, 2'b00, 0, 0, 32'h0, ns, nr);
    pin("after_reset", 32'hABC, 5'd12, 1'b1);

`ifdef MEM_TIMEOUT_EN
    issue(1, 32'h300, 32'h0, 5'd13, 32'h0, 1, 0, 2'b01, 0, 1000, 32'h0, ns, nr);
    chk("timeout_stall", 32'(ns), 32'd5);
    pin("timeout", 32'h0, 5'd13, 1'b0);
    chk("timeout_error", 32'(errorOUT), 32'd1);
    issue(1, 32'h301, 32'h0, 5'd14, 32'h0, 1, 0, 2'b00, 0, 0, 32'h0, ns, nr);
    issue(1, 32'h302, 32'h0, 5'd15, 32'h0, 1, 0, 2'b01, 1, 1, 32'h13579BDF, ns, nr);
`endif

    @(posedge clk); #1;
    bubble_inputs();
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage that consumes the EX/MEM pipeline register outputs and issues loads and stores to data memory over a valid/ready request bus with variable-latency read responses. While an access is in flight it stalls the upstream pipeline. When the instruction completes, it produces the registered MEM/WB result: the write-back value, the destination register and the write enable. It sits between the EX/MEM register and the register-file write-back port.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: maximum number of WAIT-state cycles before abort. Used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- validIN  in  1  the EX/MEM slot holds a real instruction (0 = bubble).
- aluResultIN  in  32  ALU result; this is also the memory address.
- writeDataIN  in  32  store data.
- rdAddrIN  in  5  destination register.
- pcPlus4IN  in  32  link value.
- RegWriteIN, MemWriteIN  in  1 each  control bits from EX/MEM.
- ResultSrcIN  in  2  write-back source: 00 ALU, 01 memory, 10 pcPlus4, 11 treated as ALU.
- stallOUT  out  1  hold request to the EX/MEM register (its we = ~stallOUT).
- memReqValid  out  1  request valid.
- memReqReady  in  1  memory accepts the request.
- memReqWrite  out  1  1 = store, 0 = load.
- memAddr, memWData  out  32 each  request address and store data.
- memRspValid  in  1  load data valid.
- memRData  in  32  load data.
- resultOUT  out  32  write-back value.
- rdAddrOUT  out  5  write-back destination.
- RegWriteOUT  out  1  write-back enable; only ever 1 together with validOUT.
- validOUT  out  1  one-cycle pulse per retired instruction.
- errorOUT  out  1  sticky timeout flag.

## Operation
- An instruction needs a memory access when validIN && (MemWriteIN || ResultSrcIN==01).
- States are IDLE, REQ and WAIT.
- IDLE, bubble input: at the next edge validOUT=0 and RegWriteOUT=0.
- IDLE, valid input with no memory access: at the next edge the stage registers the result and sets validOUT=1.
  - resultOUT = pcPlus4IN if ResultSrcIN==10, otherwise aluResultIN.
- IDLE, valid input with memory access:
  - stallOUT=1 combinationally in the same cycle.
  - The stage latches the address, data, rd, RegWrite, MemWrite and ResultSrc fields internally.
  - Next state is REQ.
- REQ:
  - memReqValid=1. memAddr, memWData and memReqWrite are driven from the latched fields and held stable until accepted.
  - On memReqReady with a store: the instruction completes. At the next edge validOUT=1, RegWriteOUT = latched RegWrite, resultOUT = latched aluResult, and the state returns to IDLE.
  - On memReqReady with a load: next state is WAIT.
- WAIT:
  - On memRspValid: resultOUT=memRData, validOUT=1, RegWriteOUT = latched RegWrite, next state IDLE.
- stallOUT behaviour:
  - stallOUT=1 in every cycle from detection in IDLE through the cycle before completion.
  - stallOUT=0 in the completion cycle (memReqReady for a store, memRspValid for a load), so EX/MEM advances on the same edge at which the result is registered.
- memRspValid outside WAIT is ignored.
- memReqReady outside REQ is ignored.

## Timing
- Reset values: all outputs are 0, the state is IDLE, and errorOUT is cleared. stallOUT is forced to 0 while reset is low.
- Latency, non-memory instruction: 1 cycle.
- Latency, store with immediate ready: 2 cycles (IDLE, REQ).
- Latency, load with ready and response on the first cycle of each: 3 cycles.
- Back-to-back non-memory instructions give one result per cycle. Each memory instruction occupies at least 2 cycles.
- Reset asserted mid-access: memReqValid drops asynchronously and the in-flight instruction is discarded, with no validOUT. A late response arriving after reset is ignored.

## Configuration
- MEM_TIMEOUT_EN defined:
  - An 8+ bit counter runs in WAIT.
  - If memRspValid has not arrived after TIMEOUT_CYCLES cycles, the instruction completes with resultOUT=0 and RegWriteOUT=0 (validOUT=1).
  - errorOUT is set and stays set until reset.
  - The counter clears on entry to WAIT.
- MEM_TIMEOUT_EN undefined: WAIT lasts indefinitely and errorOUT is tied to 0.

## Structure
- Package pipeline_pkg holds:
  - the ResultSrc encodings RS_ALU=2'b00, RS_MEM=2'b01, RS_PC4=2'b10;
  - the memstate_t enum {IDLE, REQ, WAIT}.
- Sub-module mem_timeout_counter (clear, enable, expired output) is instantiated only under MEM_TIMEOUT_EN.

## Test plan
- Reset, then ALU instruction: aluResultIN=0x1234, rd=5, RegWrite=1, ResultSrc=00 -> next cycle resultOUT=0x1234, rdAddrOUT=5, validOUT=1, stallOUT stays 0.
- JAL-type: ResultSrc=10, pcPlus4IN=0x104 -> resultOUT=0x104 after 1 cycle.
- Store with memReqReady held low 3 cycles: addr 0x80, data 0xDEADBEEF -> memReqValid stable with addr 0x80 and data 0xDEADBEEF for 4 cycles; stallOUT high until the accept cycle; then validOUT=1 and RegWriteOUT=0.
- Load, ready immediate, response after 2 cycles with memRData=0xCAFEF00D, rd=7 -> resultOUT=0xCAFEF00D, rdAddrOUT=7, RegWriteOUT=1; total stall of 4 cycles.
- Reset pulled low during WAIT, then a stray memRspValid -> all outputs 0, no validOUT, state IDLE.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4: load with no response -> after 4 WAIT cycles validOUT=1, RegWriteOUT=0, errorOUT=1 and stays 1 through the next instructions.
